// File: rtl/win16_sum.sv
// -----------------------------------------------------------------------------
// win16_sum -- sliding-window accumulator
//
// Keeps a running sum of the last 2**N_LOG2 accepted samples (16 by default).
// It smooths the stream from the 9-bit trapezoid waveform generator. Once the
// window is full, it produces one registered sum for each accepted sample.
//
// Optional feature (compile-time macro WIN16_SUM_AVG_EN):
//   When the macro is defined, the block adds output avg_out. avg_out is the
//   window mean, rounded half up. It is registered together with sum_out.
//
// Ports
//   clk       in   1        system clock, rising edge
//   res       in   1        asynchronous active-high reset
//   clr       in   1        synchronous clear: flushes the window, like reset
//   din_vld   in   1        sample strobe
//   din       in   DW       unsigned sample
//   sum_out   out  SW       sum of the last N accepted samples (SW = DW+N_LOG2)
//   sum_vld   out  1        1-cycle pulse: sum_out updated while window full
//   win_full  out  1        level: at least N samples accepted since reset/clr
//   avg_out   out  DW       (WIN16_SUM_AVG_EN only) rounded window mean
// -----------------------------------------------------------------------------
module win16_sum #(
  parameter int DW     = 9,
  parameter int N_LOG2 = 4
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   clr,
  input  logic                   din_vld,
  input  logic [DW-1:0]          din,
  output logic [DW+N_LOG2-1:0]   sum_out,
  output logic                   sum_vld,
`ifdef WIN16_SUM_AVG_EN
  output logic [DW-1:0]          avg_out,
`endif
  output logic                   win_full
);

  localparam int SW = DW + N_LOG2;
  localparam int N  = 1 << N_LOG2;

  localparam logic ST_FILL = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  logic [DW-1:0]     buf_q [N];
  logic [N_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [N_LOG2-1:0] fill_cnt_q, fill_cnt_d;
  logic              state_q, state_d;
  logic [SW-1:0]     sum_q, sum_d;
  logic              sum_vld_q, sum_vld_d;
  logic              win_full_q, win_full_d;
  logic              accept;
  logic              last_fill;
  logic [SW-1:0]     sum_next;

`ifdef WIN16_SUM_AVG_EN
  logic [DW-1:0]     avg_q, avg_d;

  // Round half up: add half an LSB of the divided result, then shift.
  // One extra bit absorbs the rounding carry.
  function automatic logic [DW-1:0] round_avg(input logic [SW-1:0] s);
    logic [SW:0] t;
    t = {1'b0, s} + (SW+1)'(1 << (N_LOG2-1));
    return t[N_LOG2 +: DW];
  endfunction
`endif

  // A clear on the same edge as a valid sample takes priority.
  // The sample is dropped.
  assign accept    = din_vld & ~clr;
  assign last_fill = (state_q == ST_FILL) && (fill_cnt_q == N_LOG2'(N-1));

  // The slot being overwritten holds the oldest sample. During fill that slot
  // is still zero, so the same update rule is exact from the first sample on.
  assign sum_next  = sum_q + SW'(din) - SW'(buf_q[wr_ptr_q]);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    fill_cnt_d = fill_cnt_q;
    state_d    = state_q;
    sum_d      = sum_q;
    sum_vld_d  = 1'b0;
    win_full_d = win_full_q;
`ifdef WIN16_SUM_AVG_EN
    avg_d      = avg_q;
`endif
    if (clr) begin
      wr_ptr_d   = '0;
      fill_cnt_d = '0;
      state_d    = ST_FILL;
      sum_d      = '0;
      win_full_d = 1'b0;
`ifdef WIN16_SUM_AVG_EN
      avg_d      = '0;
`endif
    end else if (accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      sum_d    = sum_next;
`ifdef WIN16_SUM_AVG_EN
      avg_d    = round_avg(sum_next);
`endif
      if (state_q == ST_RUN) begin
        sum_vld_d = 1'b1;
      end else begin
        fill_cnt_d = fill_cnt_q + 1'b1;
        if (last_fill) begin
          state_d    = ST_RUN;
          win_full_d = 1'b1;
          sum_vld_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      for (int i = 0; i < N; i++) buf_q[i] <= '0;
      wr_ptr_q   <= '0;
      fill_cnt_q <= '0;
      state_q    <= ST_FILL;
      sum_q      <= '0;
      sum_vld_q  <= 1'b0;
      win_full_q <= 1'b0;
`ifdef WIN16_SUM_AVG_EN
      avg_q      <= '0;
`endif
    end else begin
      if (clr) begin
        for (int i = 0; i < N; i++) buf_q[i] <= '0;
      end else if (accept) begin
        buf_q[wr_ptr_q] <= din;
      end
      wr_ptr_q   <= wr_ptr_d;
      fill_cnt_q <= fill_cnt_d;
      state_q    <= state_d;
      sum_q      <= sum_d;
      sum_vld_q  <= sum_vld_d;
      win_full_q <= win_full_d;
`ifdef WIN16_SUM_AVG_EN
      avg_q      <= avg_d;
`endif
    end
  end

  assign sum_out  = sum_q;
  assign sum_vld  = sum_vld_q;
  assign win_full = win_full_q;
`ifdef WIN16_SUM_AVG_EN
  assign avg_out  = avg_q;
`endif

endmodule

// File: tb/tb_win16_sum.sv
module tb_win16_sum;

  localparam int DW     = 9;
  localparam int N_LOG2 = 4;
  localparam int SW     = DW + N_LOG2;

  logic          clk = 1'b0;
  logic          res;
  logic          clr;
  logic          din_vld;
  logic [DW-1:0] din;
  logic [SW-1:0] sum_out;
  logic          sum_vld;
  logic          win_full;
`ifdef WIN16_SUM_AVG_EN
  logic [DW-1:0] avg_out;
`endif

  win16_sum #(.DW(DW), .N_LOG2(N_LOG2)) dut (
    .clk      (clk),
    .res      (res),
    .clr      (clr),
    .din_vld  (din_vld),
    .din      (din),
    .sum_out  (sum_out),
    .sum_vld  (sum_vld),
`ifdef WIN16_SUM_AVG_EN
    .avg_out  (avg_out),
`endif
    .win_full (win_full)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock of stimulus. If this sample should produce a sum_vld pulse,
  // its expected sum is queued for the monitor.
  task automatic send(input logic v, input logic [DW-1:0] d,
                      input bit exp_v, input int exp_s);
    din_vld = v;
    din     = d;
    if (exp_v) exp_q.push_back(exp_s);
    @(posedge clk);
    #1;
    din_vld = 1'b0;
  endtask

  task automatic do_clr();
    clr     = 1'b1;
    din_vld = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  // Monitor: every sum_vld pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (sum_vld === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_sum_vld: got sum_out %0d, expected no pulse", sum_out);
      end else begin
        int e;
        e = exp_q.pop_front();
        check("sum_out", int'(sum_out), e);
        check("win_full_on_vld", int'(win_full), 1);
`ifdef WIN16_SUM_AVG_EN
        check("avg_out", int'(avg_out), (e + 8) >> 4);
`endif
      end
    end
  end

  initial begin
    int hist[$];
    int s;
    res = 1'b1; clr = 1'b0; din_vld = 1'b0; din = '0;

    // Reset state
    #12;
    check("rst_sum_out", int'(sum_out), 0);
    check("rst_sum_vld", int'(sum_vld), 0);
    check("rst_win_full", int'(win_full), 0);
    #1 res = 1'b0;
    @(posedge clk); #1;

    // Test 1: constant 10
    for (int i = 1; i <= 15; i++) send(1'b1, 9'd10, 1'b0, 0);
    check("t1_not_full_15", int'(win_full), 0);
    send(1'b1, 9'd10, 1'b1, 160);
    check("t1_full", int'(win_full), 1);
    send(1'b1, 9'd10, 1'b1, 160);
    send(1'b0, 9'd0, 1'b0, 0);
    check("t1_idle_vld", int'(sum_vld), 0);
    check("t1_idle_hold", int'(sum_out), 160);

    // Test 2: ramp 1..20
    do_clr();
    check("t2_clr_sum", int'(sum_out), 0);
    check("t2_clr_full", int'(win_full), 0);
    for (int i = 1; i <= 15; i++) send(1'b1, DW'(i), 1'b0, 0);
    send(1'b1, 9'd16, 1'b1, 136);
    send(1'b1, 9'd17, 1'b1, 152);
    send(1'b1, 9'd18, 1'b1, 168);
    send(1'b1, 9'd19, 1'b1, 184);
    send(1'b1, 9'd20, 1'b1, 200);

    // Test 3: full scale, then a small constant for rounding
    do_clr();
    for (int i = 1; i <= 15; i++) send(1'b1, 9'd511, 1'b0, 0);
    for (int i = 16; i <= 20; i++) send(1'b1, 9'd511, 1'b1, 8176);
    do_clr();
    for (int i = 1; i <= 15; i++) send(1'b1, 9'd3, 1'b0, 0);
    send(1'b1, 9'd3, 1'b1, 48);

    // Test 4: gapped valid, with each sample followed by an idle clock
    do_clr();
    for (int i = 1; i <= 15; i++) begin
      send(1'b1, 9'd5, 1'b0, 0);
      send(1'b0, 9'd99, 1'b0, 0);
    end
    send(1'b1, 9'd5, 1'b1, 80);
    send(1'b0, 9'd99, 1'b0, 0);
    check("t4_gap_vld", int'(sum_vld), 0);
    check("t4_gap_hold", int'(sum_out), 80);
    send(1'b1, 9'd5, 1'b1, 80);

    // Test 5: clr together with din_vld; the sample is dropped
    clr = 1'b1; din_vld = 1'b1; din = 9'd100;
    @(posedge clk); #1;
    clr = 1'b0; din_vld = 1'b0;
    check("t5_clr_sum", int'(sum_out), 0);
    check("t5_clr_full", int'(win_full), 0);
    check("t5_clr_vld", int'(sum_vld), 0);
    for (int i = 1; i <= 15; i++) send(1'b1, 9'd7, 1'b0, 0);
    check("t5_not_full", int'(win_full), 0);
    send(1'b1, 9'd7, 1'b1, 112);

    // Test 6: async reset mid-stream, then the generator ramp 0..299
    send(1'b1, 9'd9, 1'b1, 114);
    send(1'b1, 9'd9, 1'b1, 116);
    send(1'b1, 9'd9, 1'b1, 118);
    send(1'b0, 9'd0, 1'b0, 0);
    #2 res = 1'b1;
    #1;
    check("t6_async_sum", int'(sum_out), 0);
    check("t6_async_full", int'(win_full), 0);
    check("t6_async_vld", int'(sum_vld), 0);
    repeat (2) @(posedge clk);
    #3 res = 1'b0;
    @(posedge clk); #1;
    for (int v = 0; v < 300; v++) begin
      hist.push_back(v);
      if (hist.size() > 16) void'(hist.pop_front());
      s = 0;
      foreach (hist[k]) s += hist[k];
      send(1'b1, DW'(v), hist.size() == 16, s);
    end
    send(1'b0, 9'd0, 1'b0, 0);

    // Drain: every queued expectation must have been consumed
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
